bless_inject_ctrl: RTL and testbench
====================================

BLESS_INJECT_CTRL -- requirements
Module: bless_inject_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 64: flit width, equal to the router port width; an all-zero flit means no flit.
REQ-002 SHALL have parameter DEPTH, default 4: injection FIFO depth, a power of 2 and at least 2.
REQ-003 SHALL have parameter STARVE_LIM, default 16: number of consecutive blocked cycles that counts as starvation, at least 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port pe_valid, input, 1 bit: the PE presents a flit.
REQ-007 SHALL have port pe_data, input, DATA_W bits: the PE flit.
REQ-008 SHALL have port pe_ready, output, 1 bit: the FIFO can accept a flit.
REQ-009 SHALL have port net_busy, input, 4 bits: valid flags of the W, E, S, N network flits entering the router next cycle.
REQ-010 SHALL have port dout_local, output, DATA_W bits: flit driven onto the router dinLocal port.
REQ-011 SHALL have port throttle_req, output, 1 bit: starvation flag sent to neighbours.
REQ-012 SHALL have port occupancy, output, clog2(DEPTH)+1 bits: number of flits in the FIFO.

Function
REQ-013 SHALL accept a PE flit when pe_valid and pe_ready are both 1 at a clock edge.
REQ-014 SHALL drive pe_ready = (occupancy < DEPTH), combinational from registered state only.
REQ-015 SHALL accept a zero-valued pe_data without enqueuing it.
REQ-016 SHALL store flits in a circular FIFO with read and write pointers that wrap modulo DEPTH.
REQ-017 SHALL treat the cycle as an injection slot when the FIFO is non-empty and net_busy != 4'b1111, i.e. at least one network input is free. This keeps inputs no greater than outputs for deflection.
REQ-018 SHALL, on an injection slot, register the head flit into dout_local at the next edge and pop it; dout_local is thus valid in the cycle after the slot (1-cycle latency).
REQ-019 SHALL otherwise register 0 into dout_local, so dout_local is nonzero for exactly one cycle per injected flit.
REQ-020 SHALL, on a simultaneous push and pop, keep occupancy unchanged.
REQ-021 SHALL, on a push while full, never accept the flit: pe_ready=0 and the data is ignored.
REQ-022 SHALL implement an FSM with states IDLE (FIFO empty), READY (non-empty, last cycle injected or first cycle) and BLOCKED (non-empty, the head was not injected last cycle).
REQ-023 SHALL follow these FSM transitions:
- any state -> IDLE when the FIFO becomes empty;
- IDLE -> READY on the first enqueue;
- READY -> BLOCKED when net_busy == 4'b1111;
- BLOCKED -> READY on injection.
REQ-024 SHALL keep a block counter that increments each cycle in BLOCKED, saturates at STARVE_LIM, and clears on injection or on IDLE.
REQ-025 SHALL assert throttle_req (registered) while block counter == STARVE_LIM, and deassert it in the cycle after the head is injected.
REQ-026 SHALL evaluate a push to an empty FIFO as an injection slot no earlier than the next cycle (no combinational bypass from pe_data to dout_local).

Reset
REQ-027 SHALL, on reset assertion, asynchronously set dout_local=0, throttle_req=0, occupancy=0, both pointers=0, block counter=0 and FSM=IDLE; pe_ready is then 1.
REQ-028 SHALL discard any flits held in the FIFO when reset asserts mid-operation; no partial flit appears on dout_local.
REQ-029 SHALL resume normal operation at the first clock edge after reset deasserts.

Configuration
REQ-030 SHALL, with macro INJ_STARVE_DETECT_EN defined, include the block counter and throttle_req logic per REQ-024 and REQ-025.
REQ-031 SHALL, with INJ_STARVE_DETECT_EN undefined, omit the block counter and tie throttle_req to 0; the FSM, FIFO and injection behaviour are unchanged.

Verification
REQ-032 SHALL cover single flit: push 0x1 with net_busy=0000 -> dout_local=0x1 exactly one cycle, two cycles after the push edge; occupancy returns to 0.
REQ-033 SHALL cover full FIFO: push 5 flits with net_busy=1111 -> 4 accepted, pe_ready=0 after the 4th, the 5th is held by the PE, occupancy=4.
REQ-034 SHALL cover starvation (INJ_STARVE_DETECT_EN defined): hold net_busy=1111 for 20 cycles with 1 flit queued -> throttle_req rises after 16 blocked cycles; release net_busy=1110 -> flit injected, then throttle_req=0 the cycle after.
REQ-035 SHALL cover simultaneous push/pop at occupancy 2 with net_busy=0001 -> occupancy stays 2 and the FIFO order is preserved across pointer wrap, checked over 10 flits.
REQ-036 SHALL cover mid-operation reset: occupancy=3, assert reset between edges -> dout_local=0, occupancy=0 immediately; after deassert, a new flit 0xA is injected normally.
REQ-037 SHALL cover zero-flit filtering: pe_valid=1 with pe_data=0 -> accepted, occupancy unchanged, dout_local stays 0.

Source files
------------

// File: rtl/bless_inject_ctrl.sv
// BLESS router injection controller: PE flit FIFO, slot-based injection onto dinLocal, starvation flag.
// Optional starvation detector (block counter + throttle_req) is built only with INJ_STARVE_DETECT_EN defined.
module bless_inject_ctrl #(
   parameter int DATA_W     = 64,
   parameter int DEPTH      = 4,
   parameter int STARVE_LIM = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pe_valid,
   input  logic [DATA_W-1:0]          pe_data,
   output logic                       pe_ready,
   input  logic [3:0]                 net_busy,
   output logic [DATA_W-1:0]          dout_local,
   output logic                       throttle_req,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, READY, BLOCKED} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [OCC_W-1:0]  occ_next;
   logic              push, pop;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pe_ready = (occupancy < OCC_W'(DEPTH));
      push     = pe_valid && pe_ready && (pe_data != '0);
      // A free network input keeps router inputs <= outputs, so deflection always has a port.
      pop      = (occupancy != '0) && (net_busy != 4'b1111);
      occ_next = occupancy + OCC_W'(push) - OCC_W'(pop);
   end

   // NOTE: storage needs no reset; only pointers and occupancy define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pe_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occupancy  <= '0;
         dout_local <= '0;
         state      <= IDLE;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         occupancy  <= occ_next;
         dout_local <= pop ? mem[rd_ptr] : '0;

         if (occ_next == '0) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE:    state <= READY;
               READY:   if (net_busy == 4'b1111) state <= BLOCKED;
               BLOCKED: if (pop) state <= READY;
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef INJ_STARVE_DETECT_EN
   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   logic [CNT_W-1:0] block_cnt, cnt_next;

   always_comb begin
      cnt_next = block_cnt;
      if (pop || state == IDLE)
         cnt_next = '0;
      else if (state == BLOCKED && block_cnt != CNT_W'(STARVE_LIM))
         cnt_next = block_cnt + 1'b1;
   end

   // throttle_req follows the next count so it drops the cycle after the head injects.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         block_cnt    <= '0;
         throttle_req <= 1'b0;
      end else begin
         block_cnt    <= cnt_next;
         throttle_req <= (cnt_next == CNT_W'(STARVE_LIM));
      end
   end
`else
   assign throttle_req = 1'b0;
`endif

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// Self-checking bench for bless_inject_ctrl: directed scenarios plus random traffic vs. a queue model.
// Throttle expectations follow INJ_STARVE_DETECT_EN the same way the design build does.
module tb_bless_inject_ctrl;

   localparam int DATA_W     = 64;
   localparam int DEPTH      = 4;
   localparam int STARVE_LIM = 16;
   localparam int OCC_W      = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              pe_valid;
   logic [DATA_W-1:0] pe_data;
   logic              pe_ready;
   logic [3:0]        net_busy;
   logic [DATA_W-1:0] dout_local;
   logic              throttle_req;
   logic [OCC_W-1:0]  occupancy;

   bless_inject_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
      .clk(clk), .reset(reset), .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_ready),
      .net_busy(net_busy), .dout_local(dout_local), .throttle_req(throttle_req),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: FIFO contents in order, plus the length of the current run of
   // cycles in which a queued head could not inject because all network inputs were busy.
   logic [DATA_W-1:0] q[$];
   int                stall_run = 0;

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_throttle();
`ifdef INJ_STARVE_DETECT_EN
      return stall_run > STARVE_LIM;
`else
      return 1'b0;
`endif
   endfunction

   // One clock cycle: apply inputs, check pe_ready, advance the model, then check registered outputs.
   task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [3:0] b);
      logic [DATA_W-1:0] exp_dout;
      logic              accept;
      logic              slot;
      pe_valid = v;
      pe_data  = d;
      net_busy = b;
      #1;
      check("pe_ready", DATA_W'(pe_ready), DATA_W'(q.size() < DEPTH));
      accept = v && (q.size() < DEPTH) && (d != '0);
      slot   = (q.size() != 0) && (b != 4'b1111);
      if (q.size() != 0 && b == 4'b1111) stall_run++;
      else stall_run = 0;
      exp_dout = slot ? q.pop_front() : '0;
      if (accept) q.push_back(d);
      @(posedge clk);
      #1;
      check("dout_local", dout_local, exp_dout);
      check("occupancy", DATA_W'(occupancy), DATA_W'(q.size()));
      check("throttle_req", DATA_W'(throttle_req), DATA_W'(exp_throttle()));
   endtask

   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      check("rst_dout", dout_local, '0);
      check("rst_occupancy", DATA_W'(occupancy), '0);
      check("rst_pe_ready", DATA_W'(pe_ready), 64'd1);
      check("rst_throttle", DATA_W'(throttle_req), '0);
      q.delete();
      stall_run = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0]        busy;
      logic [DATA_W-1:0] d;
      int                busy_mode;

      reset    = 1'b1;
      pe_valid = 1'b0;
      pe_data  = '0;
      net_busy = 4'b0000;
      #2;
      check("reset_dout", dout_local, '0);
      check("reset_occupancy", DATA_W'(occupancy), '0);
      check("reset_pe_ready", DATA_W'(pe_ready), 64'd1);
      check("reset_throttle", DATA_W'(throttle_req), '0);
      @(negedge clk);
      reset = 1'b0;

      // Single flit through an idle network.
      step(1'b1, 64'h1, 4'b0000);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 4'b0000);

      // Fill with all inputs busy: five offered, four accepted, PE holds the fifth.
      for (int i = 1; i <= 5; i++) step(1'b1, DATA_W'(64'h100 + i), 4'b1111);
      step(1'b1, 64'h105, 4'b1111);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 4'b0001);

      // Starvation: one queued flit held off for 20 cycles, then released.
      step(1'b1, 64'h5a, 4'b1111);
      for (int i = 0; i < 20; i++) step(1'b0, '0, 4'b1111);
      step(1'b0, '0, 4'b1110);
      for (int i = 0; i < 2; i++) step(1'b0, '0, 4'b1110);

      // Simultaneous push/pop at occupancy 2 across pointer wrap.
      step(1'b1, 64'h200, 4'b1111);
      step(1'b1, 64'h201, 4'b1111);
      for (int i = 2; i < 12; i++) step(1'b1, DATA_W'(64'h200 + i), 4'b0001);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 4'b0001);

      // Zero-valued flits are accepted but never enqueued.
      step(1'b1, '0, 4'b0000);
      step(1'b1, '0, 4'b1111);
      step(1'b0, '0, 4'b0000);

      // Mid-operation reset with three flits queued, then a fresh flit.
      for (int i = 0; i < 3; i++) step(1'b1, DATA_W'(64'h300 + i), 4'b1111);
      async_reset();
      step(1'b1, 64'hA, 4'b0000);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 4'b0000);

      // Random traffic with alternating congestion phases.
      busy_mode = 0;
      for (int i = 0; i < 600; i++) begin
         if (i % 40 == 0) busy_mode = $urandom_range(0, 2);
         case (busy_mode)
            0:       busy = 4'($urandom);
            1:       busy = ($urandom_range(0, 3) != 0) ? 4'b1111 : 4'($urandom);
            default: busy = ($urandom_range(0, 29) != 0) ? 4'b1111 : 4'b0111;
         endcase
         d = ($urandom_range(0, 7) == 0) ? '0 : {$urandom(), $urandom()};
         step($urandom_range(0, 3) != 0, d, busy);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
